// File: rtl/hex_ascii_to_bin_parser_pkg.sv
// Shared ASCII constants, FSM state encoding and sizing for the hex parser.
package hex_ascii_to_bin_parser_pkg;

    localparam logic [7:0] CHR_0    = 8'h30;
    localparam logic [7:0] CHR_9    = 8'h39;
    localparam logic [7:0] CHR_A_UC = 8'h41;
    localparam logic [7:0] CHR_F_UC = 8'h46;
    localparam logic [7:0] CHR_A_LC = 8'h61;
    localparam logic [7:0] CHR_F_LC = 8'h66;
    localparam logic [7:0] CHR_SP   = 8'h20;
    localparam logic [7:0] CHR_CR   = 8'h0D;
    localparam logic [7:0] CHR_LF   = 8'h0A;

    // Digit counter width; one bit wider than out_ndigits so the
    // incremented count can be compared against NDIGITS without wrapping.
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/hex_ascii_to_bin_parser_ascii_to_nibble.sv
// Combinational ASCII character classifier: hex digit -> nibble, plus
// separator detection (space, CR, LF). Anything else is neither.
module ascii_to_nibble
    import hex_ascii_to_bin_parser_pkg::*;
(
    input  logic [7:0] ch,
    output logic [3:0] nibble,
    output logic       is_hex,
    output logic       is_sep
);

    logic [7:0] diff;

    // Classify the character and compute its nibble value.
    always_comb begin
        diff   = 8'h00;
        is_hex = 1'b0;
        is_sep = 1'b0;
        if (ch >= CHR_0 && ch <= CHR_9) begin
            diff   = ch - CHR_0;
            is_hex = 1'b1;
        end else if (ch >= CHR_A_UC && ch <= CHR_F_UC) begin
            diff   = ch - CHR_A_UC + 8'd10;
            is_hex = 1'b1;
        end else if (ch >= CHR_A_LC && ch <= CHR_F_LC) begin
            diff   = ch - CHR_A_LC + 8'd10;
            is_hex = 1'b1;
        end else if (ch == CHR_SP || ch == CHR_CR || ch == CHR_LF) begin
            is_sep = 1'b1;
        end
        nibble = diff[3:0];
    end

endmodule

// File: rtl/hex_ascii_to_bin_parser.sv
// Streaming ASCII-hex to binary word parser.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no digits collected; separators ignored
//  ST_ACCUM | 1..NDIGITS-1 digits in acc
//  ST_EMIT  | word held on out_data/out_ndigits, out_valid=1, in_ready=0
//  ST_DRAIN | after an illegal char; discard until a separator
module hex_ascii_to_bin_parser
    import hex_ascii_to_bin_parser_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NDIGITS = DATA_W / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_ndigits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_pulse
);

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  acc, acc_nxt, acc_shift;
    logic [CNT_W-1:0]   count, count_nxt, count_inc;
    logic [DATA_W-1:0]  out_data_nxt;
    logic [3:0]         out_ndigits_nxt;
    logic               err_nxt;
    logic [3:0]         nibble;
    logic               is_hex, is_sep;
    logic               take;

    ascii_to_nibble u_nib (
        .ch     (in_data),
        .nibble (nibble),
        .is_hex (is_hex),
        .is_sep (is_sep)
    );

    // Handshake outputs decode straight from the state register so in_ready
    // never depends on in_valid.
    assign in_ready  = (state != ST_EMIT);
    assign out_valid = (state == ST_EMIT);
    assign take      = in_valid && in_ready;
    assign acc_shift = {acc[DATA_W-5:0], nibble};
    assign count_inc = count + 1'b1;

    // Next-state, accumulator, counter and output-word decode.
    always_comb begin
        state_nxt       = state;
        acc_nxt         = acc;
        count_nxt       = count;
        out_data_nxt    = out_data;
        out_ndigits_nxt = out_ndigits;
        err_nxt         = 1'b0;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (take) begin
                    if (is_hex) begin
                        if (count_inc == CNT_W'(NDIGITS)) begin
                            out_data_nxt    = acc_shift;
                            out_ndigits_nxt = count_inc[3:0];
                            acc_nxt         = '0;
                            count_nxt       = '0;
                            state_nxt       = ST_EMIT;
                        end else begin
                            acc_nxt   = acc_shift;
                            count_nxt = count_inc;
                            state_nxt = ST_ACCUM;
                        end
                    end else if (is_sep) begin
                        if (state == ST_ACCUM) begin
                            out_data_nxt    = acc;
                            out_ndigits_nxt = count[3:0];
                            acc_nxt         = '0;
                            count_nxt       = '0;
                            state_nxt       = ST_EMIT;
                        end
                    end else begin
                        err_nxt   = 1'b1;
                        acc_nxt   = '0;
                        count_nxt = '0;
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (take && is_sep) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc         <= '0;
            count       <= '0;
            out_data    <= '0;
            out_ndigits <= '0;
            err_pulse   <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            count       <= count_nxt;
            out_data    <= out_data_nxt;
            out_ndigits <= out_ndigits_nxt;
            err_pulse   <= err_nxt;
        end
    end

endmodule
